// File: rtl/fork_join_ctrl.sv
// Fork/join scheduler: one accepted start launches up to NUM_TASKS timed child
// jobs and releases the parent with a single parent_go pulse per join mode.
module fork_join_ctrl #(
  parameter int unsigned NUM_TASKS = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [NUM_TASKS-1:0]       task_en,
  input  logic [NUM_TASKS*CNT_W-1:0] dur,
  input  logic                       kill,
  output logic                       busy,
  output logic                       parent_go,
  output logic [NUM_TASKS-1:0]       task_active,
  output logic [NUM_TASKS-1:0]       task_done
);

  localparam logic [1:0] MODE_JOIN_ANY  = 2'b01;
  localparam logic [1:0] MODE_JOIN_NONE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_PARENT,
    S_DRAIN
  } state_t;

  state_t                             state_q, state_d;
  logic   [1:0]                       mode_q, mode_d;
  logic   [NUM_TASKS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic   [NUM_TASKS-1:0]             active_q, active_d;
  logic   [NUM_TASKS-1:0]             done_q, done_d;
  logic                               pg_q, pg_d;
  logic                               busy_q, busy_d;

  logic   [NUM_TASKS-1:0]             fin;
  logic   [NUM_TASKS-1:0]             remain;
  logic                               accept;
  logic                               release_go;

  // Next-state, counter and output computation
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    done_d     = '0;
    pg_d       = 1'b0;
    busy_d     = 1'b0;
    fin        = '0;
    release_go = 1'b0;

    // A task finishes on the edge its counter steps from 1 to 0
    for (int unsigned i = 0; i < NUM_TASKS; i++) begin
      fin[i] = active_q[i] && (cnt_q[i] == CNT_W'(1));
      if (active_q[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
    remain   = active_q & ~fin;
    active_d = remain;
    done_d   = fin;

    // busy_q gate keeps a start from landing in the trailing busy cycle
    accept = (state_q == S_IDLE) && (active_q == '0) && !busy_q && start && !kill;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d   = mode;
          active_d = task_en;
          for (int unsigned i = 0; i < NUM_TASKS; i++) begin
            if (task_en[i]) begin
              cnt_d[i] = (dur[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1) : dur[i*CNT_W +: CNT_W];
            end
          end
          if ((task_en == '0) || (mode == MODE_JOIN_NONE)) begin
            pg_d    = 1'b1;
            state_d = S_DRAIN;
          end else begin
            state_d = S_WAIT_PARENT;
          end
        end
      end
      S_WAIT_PARENT: begin
        if (mode_q == MODE_JOIN_ANY) begin
          release_go = (fin != '0);
        end else begin
          release_go = (fin != '0) && (remain == '0);
        end
        if (release_go) begin
          pg_d    = 1'b1;
          state_d = (remain == '0) ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (active_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // busy trails the last task_active by one cycle
    busy_d = (state_d != S_IDLE) || (active_q != '0);

    if (kill) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      active_d = '0;
      done_d   = '0;
      pg_d     = 1'b0;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'b00;
      cnt_q    <= '0;
      active_q <= '0;
      done_q   <= '0;
      pg_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
      pg_q     <= pg_d;
      busy_q   <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign parent_go   = pg_q;
  assign task_active = active_q;
  assign task_done   = done_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Scoreboard bench for fork_join_ctrl: launches push expected parent_go/task_done
// events; a monitor pops and compares whenever the DUT pulses either output.
module tb_fork_join_ctrl;

  localparam int unsigned NT = 3;
  localparam int unsigned CW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic [NT-1:0]    task_en;
  logic [NT*CW-1:0] dur;
  logic             kill;
  logic             busy;
  logic             parent_go;
  logic [NT-1:0]    task_active;
  logic [NT-1:0]    task_done;

  fork_join_ctrl #(.NUM_TASKS(NT), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .task_en    (task_en),
    .dur        (dur),
    .kill       (kill),
    .busy       (busy),
    .parent_go  (parent_go),
    .task_active(task_active),
    .task_done  (task_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int unsigned   c;
    logic          pg;
    logic [NT-1:0] dn;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int unsigned acc;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  // Start a fork and push the expected event stream derived from mode/en/dur
  task automatic launch(input logic [1:0] m, input logic [NT-1:0] en, input logic [NT*CW-1:0] d);
    int unsigned eff [NT];
    int unsigned maxe;
    int unsigned mine;
    int unsigned pge;
    logic [CW-1:0] f;
    ev_t e;
    @(negedge clk);
    mode = m; task_en = en; dur = d; start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
    task_en = ~en;
    dur = ~d;
    maxe = 0;
    mine = 1000;
    for (int i = 0; i < NT; i++) begin
      f = d[i*CW +: CW];
      eff[i] = en[i] ? ((f == 0) ? 1 : int'(f)) : 0;
      if (en[i] && eff[i] > maxe) maxe = eff[i];
      if (en[i] && eff[i] < mine) mine = eff[i];
    end
    if (en == '0 || m == 2'b10) pge = 0;
    else if (m == 2'b01) pge = mine;
    else pge = maxe;
    for (int unsigned t = 0; t <= maxe; t++) begin
      e.c = acc + t;
      e.pg = (t == pge);
      for (int i = 0; i < NT; i++) e.dn[i] = en[i] && (eff[i] == t);
      if (e.pg || e.dn != '0) sb.push_back(e);
    end
  endtask

  // Park at the negedge following edge e of the current fork
  task automatic wait_to(input int unsigned e);
    int unsigned t;
    t = acc + e;
    while (cyc < t || (cyc == t && clk)) @(negedge clk);
    if (cyc != t) chk("wait_to overshoot", cyc, t);
  endtask

  task automatic wait_idle(input int limit);
    for (int k = 0; k < limit && busy; k++) @(negedge clk);
    chk("idle reached", busy, 0);
  endtask

  task automatic run_join();
    launch(2'b00, 3'b111, {8'd30, 8'd20, 8'd10});
    wait_to(14);
    mode = 2'b10; task_en = 3'b001; dur = {8'd0, 8'd0, 8'd5}; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_to(15);
    chk("join active@15", task_active, 3'b110);
    chk("join busy@15", busy, 1);
    wait_to(30);
    chk("join active@30", task_active, 0);
    chk("join busy@30", busy, 1);
    wait_to(31);
    chk("join busy@31", busy, 0);
  endtask

  // Monitor: every pulse must match the head of the scoreboard
  initial begin
    ev_t exp_e;
    ev_t got;
    forever begin
      @(negedge clk);
      if (rst_n && (parent_go || task_done != '0)) begin
        got.c = cyc; got.pg = parent_go; got.dn = task_done;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected event: cyc=%0d pg=%0b done=%b", cyc, parent_go, task_done);
        end else begin
          exp_e = sb.pop_front();
          if (exp_e != got) begin
            bad++;
            $display("FAIL event: got cyc=%0d pg=%0b done=%b expected cyc=%0d pg=%0b done=%b",
                     got.c, got.pg, got.dn, exp_e.c, exp_e.pg, exp_e.dn);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; mode = 2'b00; task_en = '0; dur = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset parent_go", parent_go, 0);
    chk("reset active", task_active, 0);
    chk("reset done", task_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // join_none, tasks 0 and 1
    launch(2'b10, 3'b011, {8'd30, 8'd20, 8'd10});
    wait_to(0);
    chk("jn active@0", task_active, 3'b011);
    chk("jn busy@0", busy, 1);
    wait_to(10);
    chk("jn active@10", task_active, 3'b010);
    wait_to(20);
    chk("jn active@20", task_active, 0);
    chk("jn busy@20", busy, 1);
    wait_to(21);
    chk("jn busy@21", busy, 0);

    // join, with an ignored start mid-fork
    run_join();

    // join_any with simultaneous first completions
    launch(2'b01, 3'b111, {8'd9, 8'd5, 8'd5});
    wait_to(6);
    chk("ja active@6", task_active, 3'b100);
    wait_to(9);
    chk("ja busy@9", busy, 1);
    wait_to(10);
    chk("ja busy@10", busy, 0);

    // zero duration counts as one cycle
    launch(2'b00, 3'b001, {8'd0, 8'd0, 8'd0});
    wait_to(0);
    chk("d0 active@0", task_active, 3'b001);
    wait_to(1);
    chk("d0 active@1", task_active, 0);
    wait_to(2);
    chk("d0 busy@2", busy, 0);

    // empty fork in join mode
    launch(2'b00, 3'b000, {8'd4, 8'd4, 8'd4});
    wait_to(0);
    chk("empty busy@0", busy, 1);
    chk("empty active@0", task_active, 0);
    wait_to(1);
    chk("empty busy@1", busy, 0);

    // kill in the cycle ending at edge 10
    launch(2'b11, 3'b111, {8'd30, 8'd20, 8'd10});
    wait_to(9);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("kill active", task_active, 0);
    chk("kill busy", busy, 0);
    chk("kill done", task_done, 0);
    chk("kill parent_go", parent_go, 0);
    launch(2'b00, 3'b010, {8'd0, 8'd3, 8'd0});
    wait_to(3);
    wait_idle(10);

    // asynchronous reset in the middle of a join
    launch(2'b00, 3'b111, {8'd30, 8'd20, 8'd10});
    wait_to(6);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst active", task_active, 0);
    chk("rst parent_go", parent_go, 0);
    chk("rst done", task_done, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_join();

    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
